// File: rtl/io_bridge_pkg.sv
// ============================================================================
// Module      : io_bridge_pkg
// Description : Shared types and helpers for the IO bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] c_err_rdata_default = 32'hFFFF_FFFF;

    // A single-slave bridge still carries a 1-bit index field.
    function automatic int sel_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_bridge_if.sv
// ============================================================================
// Module      : io_bridge_if
// Description : CPU-side and peripheral-side signals of the IO bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_bridge_if #(
    parameter int NUM_SLAVES = 5,
    parameter int DATA_W     = 32,
    parameter int SEL_LSB    = 8
);
    logic                         cpu_valid;
    logic                         cpu_we;
    logic [31:0]                  cpu_addr;
    logic [DATA_W-1:0]            cpu_wdata;
    logic [DATA_W/8-1:0]          cpu_wmask;
    logic [DATA_W-1:0]            cpu_rdata;
    logic                         cpu_stall;
    logic                         cpu_err;
    logic [NUM_SLAVES-1:0]        s_req;
    logic                         s_we;
    logic [SEL_LSB-1:0]           s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [DATA_W/8-1:0]          s_wmask;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]        s_ack;
    logic [7:0]                   err_count;
    logic [31:0]                  last_err_addr;

    // Environment view: the core plus the peripherals.
    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_wmask, s_rdata, s_ack,
        input  cpu_rdata, cpu_stall, cpu_err, s_req, s_we, s_addr, s_wdata, s_wmask,
        input  err_count, last_err_addr
    );

    // Bridge view.
    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_wmask, s_rdata, s_ack,
        output cpu_rdata, cpu_stall, cpu_err, s_req, s_we, s_addr, s_wdata, s_wmask,
        output err_count, last_err_addr
    );

endinterface

`default_nettype wire

// File: rtl/io_bridge.sv
// ============================================================================
// Module      : io_bridge
// Description : Routes core IO accesses to one of NUM_SLAVES peripherals over
//               req/ack, stalling the core until ack, decode error or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int                NUM_SLAVES = 5,
    parameter int                DATA_W     = 32,
    parameter int                SEL_LSB    = 8,
    parameter int                TIMEOUT    = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA  = DATA_W'(c_err_rdata_default)
) (
    input  logic       clk,
    input  logic       reset,
    io_bridge_if.slave bus
);

    localparam int c_sel_w  = sel_w(NUM_SLAVES);
    localparam int c_cnt_w  = $clog2(TIMEOUT + 1);
    localparam int c_mask_w = DATA_W / 8;

    localparam logic [c_sel_w:0]   c_num_slaves = (c_sel_w + 1)'(NUM_SLAVES);
    localparam logic [c_cnt_w-1:0] c_timeout    = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    state_t                r_state, w_state_nxt;
    logic [NUM_SLAVES-1:0] r_req, w_req_nxt;
    logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                  r_err, w_err_nxt;
    logic [DATA_W-1:0]     r_rdata, w_rdata_nxt, w_sel_rdata;
    logic [7:0]            r_err_count, w_err_count_nxt;
    logic [31:0]           r_last_err_addr, w_last_err_addr_nxt;

    logic                  r_we;
    logic [31:0]           r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [c_mask_w-1:0]   r_wmask;

    logic                  w_latch;
    logic                  w_ack;
    logic                  w_decode_ok;
    logic [c_sel_w-1:0]    w_cpu_index;
    logic [c_sel_w-1:0]    w_lat_index;

    assign w_cpu_index = bus.cpu_addr[SEL_LSB +: c_sel_w];
    assign w_lat_index = r_addr[SEL_LSB +: c_sel_w];
    assign w_decode_ok = ({1'b0, w_cpu_index} < c_num_slaves);
    assign w_cnt_inc   = r_cnt + c_cnt_one;

    // Read data and ack of the slave addressed by the latched index.
    always_comb begin
        w_sel_rdata = '0;
        w_ack       = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_lat_index == c_sel_w'(i)) begin
                w_sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
                w_ack       = bus.s_ack[i];
            end
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_req_nxt           = r_req;
        w_cnt_nxt           = r_cnt;
        w_err_nxt           = r_err;
        w_rdata_nxt         = r_rdata;
        w_err_count_nxt     = r_err_count;
        w_last_err_addr_nxt = r_last_err_addr;
        w_latch             = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.cpu_valid) begin
                    w_latch = 1'b1;
                    if (w_decode_ok) begin
                        w_state_nxt = REQ;
                        w_req_nxt   = NUM_SLAVES'(1) << w_cpu_index;
                    end else begin
                        w_state_nxt = RESP;
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = ERR_RDATA;
                    end
                end
            end
            REQ: begin
                w_cnt_nxt = w_cnt_inc;
                // An ack on the final allowed cycle still counts as success.
                if (w_ack) begin
                    w_req_nxt   = '0;
                    w_rdata_nxt = w_sel_rdata;
                    w_state_nxt = RESP;
                end else if (w_cnt_inc == c_timeout) begin
                    w_req_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = ERR_RDATA;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_err_nxt   = 1'b0;
                if (r_err) begin
                    w_err_count_nxt     = (r_err_count == 8'hFF) ? r_err_count
                                                                 : r_err_count + 8'd1;
                    w_last_err_addr_nxt = r_addr;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_req           <= '0;
            r_cnt           <= '0;
            r_err           <= 1'b0;
            r_rdata         <= '0;
            r_err_count     <= '0;
            r_last_err_addr <= '0;
            r_we            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_wmask         <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_req           <= w_req_nxt;
            r_cnt           <= w_cnt_nxt;
            r_err           <= w_err_nxt;
            r_rdata         <= w_rdata_nxt;
            r_err_count     <= w_err_count_nxt;
            r_last_err_addr <= w_last_err_addr_nxt;
            if (w_latch) begin
                r_we    <= bus.cpu_we;
                r_addr  <= bus.cpu_addr;
                r_wdata <= bus.cpu_wdata;
                r_wmask <= bus.cpu_wmask;
            end
        end
    end

    assign bus.cpu_stall     = bus.cpu_valid & (r_state != RESP);
    assign bus.cpu_rdata     = r_rdata;
    assign bus.cpu_err       = r_err;
    assign bus.s_req         = r_req;
    assign bus.s_we          = r_we;
    assign bus.s_addr        = r_addr[SEL_LSB-1:0];
    assign bus.s_wdata       = r_wdata;
    assign bus.s_wmask       = r_wmask;
    assign bus.err_count     = r_err_count;
    assign bus.last_err_addr = r_last_err_addr;

endmodule

`default_nettype wire
